// File: rtl/sha256_job_arbiter.sv
// rtl/sha256_job_arbiter.sv - round-robin job arbiter sharing one single-block SHA-256 core
// Optional RUN-state timeout enabled by defining SHA_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module sha256_job_arbiter #(
    parameter int NREQ         = 2,
    parameter int RST_CYCLES   = 3,
    parameter int BLANK_CYCLES = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*512-1:0]      req_msg,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [255:0]             rsp_hash,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     core_reset,
    output logic [511:0]             core_message,
    input  logic                     core_ready,
    input  logic [255:0]             core_hash
);

    localparam int IDW = $clog2(NREQ);
    localparam logic [8:0] RST_LIM   = 9'(RST_CYCLES - 1);
    localparam logic [8:0] BLANK_LIM = 9'(BLANK_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic           any_req;
    logic [8:0]     cnt;
    logic [8:0]     cnt_inc;
    logic           capture;
    logic           timeout_hit;
    int             idx;

    // First requesting index at or above ptr, wrapping modulo NREQ.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                grant   = IDW'(idx);
            end
        end
    end

    assign cnt_inc = (cnt == 9'h1FF) ? cnt : cnt + 9'd1;
    // core_ready is stale from the previous job until the blanking window has passed.
    assign capture = (state == RUN) && core_ready && (cnt >= BLANK_LIM);

`ifdef SHA_ARB_TIMEOUT_EN
    localparam logic [8:0] TMO_LIM = 9'(TIMEOUT - 1);
    assign timeout_hit = (state == RUN) && !capture && (cnt >= TMO_LIM);

    logic rsp_err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if (capture) begin
            rsp_err_q <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err_q <= 1'b1;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any_req) state_nx = LOAD;
            LOAD: if (cnt >= RST_LIM) state_nx = RUN;
            RUN:  if (capture || timeout_hit) state_nx = DONE;
            DONE: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Accept pulse is suppressed while reset is asserted so the reset view is clean.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && any_req) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign rsp_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign core_reset = (state != RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            cnt          <= '0;
            rsp_id       <= '0;
            rsp_hash     <= '0;
            core_message <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        core_message <= req_msg[grant*512 +: 512];
                        rsp_id       <= grant;
                    end
                end
                LOAD: begin
                    if (cnt >= RST_LIM) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    cnt <= cnt_inc;
                    if (capture) begin
                        rsp_hash <= core_hash;
                    end else if (timeout_hit) begin
                        rsp_hash <= '0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
